// File: rtl/fft_output_streamer.sv
// ---------------------------------------------------------------------------
// fft_output_streamer
//
// Drains one FFT frame from the parallel-to-serial stage and sends it to the
// host as a byte stream. When the FFT core signals that a frame is ready, this
// block does the following:
//   - loads the parallel-to-serial stage;
//   - sends a HEADER byte so the host can find the start of the frame;
//   - strobes each result word out of the stage, one at a time;
//   - sends each word as two bytes, most significant byte first, on a
//     valid/ready link.
//
// Ports:
//   clk          rising-edge clock
//   n_rst        asynchronous active-low reset
//   fft_done     one-cycle pulse, FFT results ready on the stage inputs
//   serial_in    current word from the parallel-to-serial stage
//   load_enable  one-cycle load pulse to the parallel-to-serial stage
//   out_strobe   one-cycle shift pulse to the parallel-to-serial stage
//   byte_out     stream data to the host link
//   byte_valid   stream valid
//   byte_ready   stream ready from the host link
//   busy         high whenever a frame is in progress
//   frame_done   one-cycle pulse after the last byte of a frame transfers
//   overrun      sticky flag, fft_done arrived while a frame was in progress
// ---------------------------------------------------------------------------
module fft_output_streamer #(
   parameter int         WORDS  = 32,
   parameter int         DATA_W = 16,
   parameter logic [7:0] HEADER = 8'hA5
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              fft_done,
   input  logic [DATA_W-1:0] serial_in,
   output logic              load_enable,
   output logic              out_strobe,
   output logic [7:0]        byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              busy,
   output logic              frame_done,
   output logic              overrun
);

   localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      HDR,
      STROBE,
      CAPTURE,
      SEND_HI,
      SEND_LO,
      DONE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  word_cnt;
   logic [DATA_W-1:0] word_reg;
   logic              transfer;
   logic              last_word;

   assign transfer  = byte_valid && byte_ready;
   assign last_word = (word_cnt == CNT_W'(WORDS - 1));

   // State register. A reset drops the frame at once. The host finds the
   // start of the next frame by looking for the HEADER byte.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath registers:
   // - word_cnt is cleared when the stage is loaded. It advances only after
   //   the low byte of a word transfers, so it always holds the index of the
   //   word in flight.
   // - word_reg is captured one cycle after the strobe, because the stage
   //   registers its output on the strobe edge.
   // - overrun is sticky. A start request that arrives outside IDLE is
   //   dropped and flagged here, and is never queued.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         word_cnt <= '0;
         word_reg <= '0;
         overrun  <= 1'b0;
      end else begin
         if (state == LOAD) begin
            word_cnt <= '0;
         end else if (state == SEND_LO && transfer && !last_word) begin
            word_cnt <= word_cnt + 1'b1;
         end
         if (state == CAPTURE) begin
            word_reg <= serial_in;
         end
         if (fft_done && state != IDLE) begin
            overrun <= 1'b1;
         end
      end
   end

   // Next-state logic and Moore output decode. Every output depends only on
   // the registered state and the held word. byte_out and byte_valid
   // therefore stay stable while the sink stalls, and valid is never dropped
   // before a transfer. The FSM issues no strobe after the last word, so the
   // zero fill from the stage never reaches the host.
   always_comb begin
      state_next  = state;
      load_enable = 1'b0;
      out_strobe  = 1'b0;
      byte_valid  = 1'b0;
      byte_out    = 8'h00;
      busy        = 1'b1;
      frame_done  = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (fft_done) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            load_enable = 1'b1;
            state_next  = HDR;
         end
         HDR: begin
            byte_valid = 1'b1;
            byte_out   = HEADER;
            if (transfer) begin
               state_next = STROBE;
            end
         end
         STROBE: begin
            out_strobe = 1'b1;
            state_next = CAPTURE;
         end
         CAPTURE: begin
            state_next = SEND_HI;
         end
         SEND_HI: begin
            byte_valid = 1'b1;
            byte_out   = word_reg[DATA_W-1 -: 8];
            if (transfer) begin
               state_next = SEND_LO;
            end
         end
         SEND_LO: begin
            byte_valid = 1'b1;
            byte_out   = word_reg[7:0];
            if (transfer) begin
               state_next = last_word ? DONE : STROBE;
            end
         end
         DONE: begin
            frame_done = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
